xfcp_upstream_arb: RTL and testbench

- Shares one XFCP downstream switch between several upstream transports, e.g. the UART and UDP XFCP interfaces on the board.
- Arbitrates request frames from the upstream ports onto the single downstream request stream, one whole frame at a time, using round-robin.
- Records the origin of each granted request, and steers each downstream response frame back to the port whose request is oldest and still unanswered.

---
 rtl/xfcp_arb_pkg.sv | 21 ++
 rtl/xfcp_arb_route_fifo.sv | 46 ++++
 rtl/xfcp_upstream_arb.sv | 159 +++++++++++++++
 tb/tb_xfcp_upstream_arb.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/xfcp_arb_pkg.sv
// Shared definitions for the XFCP upstream arbiter: FSM encodings and
// port-index sizing.
package xfcp_arb_pkg;

  typedef enum logic [0:0] {
    REQ_IDLE = 1'b0,
    REQ_XFER = 1'b1
  } req_state_t;

  typedef enum logic [1:0] {
    RSP_IDLE  = 2'd0,
    RSP_ROUTE = 2'd1,
    RSP_DROP  = 2'd2
  } rsp_state_t;

  // A port index needs at least one bit even when only one port exists.
  function automatic int unsigned port_idx_width(input int unsigned ports);
    return (ports > 1) ? $clog2(ports) : 1;
  endfunction

endpackage

// File: rtl/xfcp_arb_route_fifo.sv
// FIFO of upstream port indices recording the origin of each granted request.
module xfcp_arb_route_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Extra pointer bit distinguishes a wrapped (full) FIFO from an empty one.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count    = wr_ptr - rd_ptr;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full)
      mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/xfcp_upstream_arb.sv
// Round-robin arbiter sharing one XFCP switch between several upstream
// transports; responses are steered back in request order.
module xfcp_upstream_arb
  import xfcp_arb_pkg::*;
#(
  parameter int unsigned PORTS       = 2,
  parameter int unsigned ROUTE_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [PORTS*8-1:0]            up_xfcp_in_tdata,
  input  logic [PORTS-1:0]              up_xfcp_in_tvalid,
  output logic [PORTS-1:0]              up_xfcp_in_tready,
  input  logic [PORTS-1:0]              up_xfcp_in_tlast,
  input  logic [PORTS-1:0]              up_xfcp_in_tuser,
  output logic [PORTS*8-1:0]            up_xfcp_out_tdata,
  output logic [PORTS-1:0]              up_xfcp_out_tvalid,
  input  logic [PORTS-1:0]              up_xfcp_out_tready,
  output logic [PORTS-1:0]              up_xfcp_out_tlast,
  output logic [PORTS-1:0]              up_xfcp_out_tuser,
  output logic [7:0]                    down_xfcp_out_tdata,
  output logic                          down_xfcp_out_tvalid,
  input  logic                          down_xfcp_out_tready,
  output logic                          down_xfcp_out_tlast,
  output logic                          down_xfcp_out_tuser,
  input  logic [7:0]                    down_xfcp_in_tdata,
  input  logic                          down_xfcp_in_tvalid,
  output logic                          down_xfcp_in_tready,
  input  logic                          down_xfcp_in_tlast,
  input  logic                          down_xfcp_in_tuser,
  output logic [$clog2(ROUTE_DEPTH):0]  outstanding,
  output logic                          drop_pulse
);

  localparam int unsigned IW = port_idx_width(PORTS);

  req_state_t req_state, req_next;
  rsp_state_t rsp_state, rsp_next;

  logic [IW-1:0] grant;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] arb_idx;
  logic          arb_found;
  logic [IW-1:0] rsp_port;
  logic [IW-1:0] fifo_head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_push;
  logic          fifo_pop;

  // First requesting port at or after the pointer, wrapping around.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int unsigned k = 0; k < PORTS; k++) begin
      if (!arb_found && up_xfcp_in_tvalid[(32'(rr_ptr) + k) % PORTS]) begin
        arb_found = 1'b1;
        arb_idx   = IW'((32'(rr_ptr) + k) % PORTS);
      end
    end
  end

  assign fifo_push = (req_state == REQ_IDLE) && arb_found && !fifo_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_state <= REQ_IDLE;
      rsp_state <= RSP_IDLE;
      grant     <= '0;
      rr_ptr    <= '0;
      rsp_port  <= '0;
      drop_pulse <= 1'b0;
    end else begin
      req_state  <= req_next;
      rsp_state  <= rsp_next;
      drop_pulse <= (rsp_state == RSP_DROP) && down_xfcp_in_tvalid && down_xfcp_in_tlast;
      if (fifo_push) begin
        grant  <= arb_idx;
        rr_ptr <= IW'((32'(arb_idx) + 1) % PORTS);
      end
      if (rsp_state == RSP_IDLE && down_xfcp_in_tvalid && !fifo_empty)
        rsp_port <= fifo_head;
    end
  end

  always_comb begin
    req_next             = req_state;
    up_xfcp_in_tready    = '0;
    down_xfcp_out_tvalid = 1'b0;
    down_xfcp_out_tdata  = '0;
    down_xfcp_out_tlast  = 1'b0;
    down_xfcp_out_tuser  = 1'b0;
    case (req_state)
      REQ_IDLE: begin
        if (fifo_push)
          req_next = REQ_XFER;
      end
      REQ_XFER: begin
        down_xfcp_out_tvalid     = up_xfcp_in_tvalid[grant];
        down_xfcp_out_tdata      = up_xfcp_in_tdata[8*grant +: 8];
        down_xfcp_out_tlast      = up_xfcp_in_tlast[grant];
        down_xfcp_out_tuser      = up_xfcp_in_tuser[grant];
        up_xfcp_in_tready[grant] = down_xfcp_out_tready;
        if (up_xfcp_in_tvalid[grant] && down_xfcp_out_tready && up_xfcp_in_tlast[grant])
          req_next = REQ_IDLE;
      end
      default: req_next = REQ_IDLE;
    endcase
  end

  always_comb begin
    rsp_next            = rsp_state;
    fifo_pop            = 1'b0;
    down_xfcp_in_tready = 1'b0;
    up_xfcp_out_tvalid  = '0;
    up_xfcp_out_tdata   = '0;
    up_xfcp_out_tlast   = '0;
    up_xfcp_out_tuser   = '0;
    case (rsp_state)
      RSP_IDLE: begin
        if (down_xfcp_in_tvalid)
          rsp_next = fifo_empty ? RSP_DROP : RSP_ROUTE;
      end
      RSP_ROUTE: begin
        up_xfcp_out_tvalid[rsp_port]         = down_xfcp_in_tvalid;
        up_xfcp_out_tdata[8*rsp_port +: 8]   = down_xfcp_in_tdata;
        up_xfcp_out_tlast[rsp_port]          = down_xfcp_in_tlast;
        up_xfcp_out_tuser[rsp_port]          = down_xfcp_in_tuser;
        down_xfcp_in_tready                  = up_xfcp_out_tready[rsp_port];
        if (down_xfcp_in_tvalid && up_xfcp_out_tready[rsp_port] && down_xfcp_in_tlast) begin
          fifo_pop = 1'b1;
          rsp_next = RSP_IDLE;
        end
      end
      RSP_DROP: begin
        down_xfcp_in_tready = 1'b1;
        if (down_xfcp_in_tvalid && down_xfcp_in_tlast)
          rsp_next = RSP_IDLE;
      end
      default: rsp_next = RSP_IDLE;
    endcase
  end

  xfcp_arb_route_fifo #(
    .DEPTH (ROUTE_DEPTH),
    .WIDTH (IW)
  ) u_route_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (arb_idx),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (outstanding)
  );

endmodule

// File: tb/tb_xfcp_upstream_arb.sv
// Directed bench for xfcp_upstream_arb with two ports and a four-entry route FIFO.
module tb_xfcp_upstream_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] up_xfcp_in_tdata;
  logic [1:0]  up_xfcp_in_tvalid;
  logic [1:0]  up_xfcp_in_tready;
  logic [1:0]  up_xfcp_in_tlast;
  logic [1:0]  up_xfcp_in_tuser;
  logic [15:0] up_xfcp_out_tdata;
  logic [1:0]  up_xfcp_out_tvalid;
  logic [1:0]  up_xfcp_out_tready;
  logic [1:0]  up_xfcp_out_tlast;
  logic [1:0]  up_xfcp_out_tuser;
  logic [7:0]  down_xfcp_out_tdata;
  logic        down_xfcp_out_tvalid;
  logic        down_xfcp_out_tready;
  logic        down_xfcp_out_tlast;
  logic        down_xfcp_out_tuser;
  logic [7:0]  down_xfcp_in_tdata;
  logic        down_xfcp_in_tvalid;
  logic        down_xfcp_in_tready;
  logic        down_xfcp_in_tlast;
  logic        down_xfcp_in_tuser;
  logic [2:0]  outstanding;
  logic        drop_pulse;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  xfcp_upstream_arb #(
    .PORTS       (2),
    .ROUTE_DEPTH (4)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .up_xfcp_in_tdata     (up_xfcp_in_tdata),
    .up_xfcp_in_tvalid    (up_xfcp_in_tvalid),
    .up_xfcp_in_tready    (up_xfcp_in_tready),
    .up_xfcp_in_tlast     (up_xfcp_in_tlast),
    .up_xfcp_in_tuser     (up_xfcp_in_tuser),
    .up_xfcp_out_tdata    (up_xfcp_out_tdata),
    .up_xfcp_out_tvalid   (up_xfcp_out_tvalid),
    .up_xfcp_out_tready   (up_xfcp_out_tready),
    .up_xfcp_out_tlast    (up_xfcp_out_tlast),
    .up_xfcp_out_tuser    (up_xfcp_out_tuser),
    .down_xfcp_out_tdata  (down_xfcp_out_tdata),
    .down_xfcp_out_tvalid (down_xfcp_out_tvalid),
    .down_xfcp_out_tready (down_xfcp_out_tready),
    .down_xfcp_out_tlast  (down_xfcp_out_tlast),
    .down_xfcp_out_tuser  (down_xfcp_out_tuser),
    .down_xfcp_in_tdata   (down_xfcp_in_tdata),
    .down_xfcp_in_tvalid  (down_xfcp_in_tvalid),
    .down_xfcp_in_tready  (down_xfcp_in_tready),
    .down_xfcp_in_tlast   (down_xfcp_in_tlast),
    .down_xfcp_in_tuser   (down_xfcp_in_tuser),
    .outstanding          (outstanding),
    .drop_pulse           (drop_pulse)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Sends one request frame from a port with the switch always ready.
  task automatic req_frame(input int port, input int n, input logic [7:0] base, input int exp_wait);
    int w;
    w = 0;
    up_xfcp_in_tvalid[port]       = 1'b1;
    up_xfcp_in_tdata[port*8 +: 8] = base;
    up_xfcp_in_tlast[port]        = (n == 1);
    #1;
    while (up_xfcp_in_tready[port] !== 1'b1 && w < 20) begin
      cyc();
      w++;
    end
    chk("req_wait", w, exp_wait);
    for (int b = 0; b < n; b++) begin
      up_xfcp_in_tdata[port*8 +: 8] = base + 8'(b);
      up_xfcp_in_tlast[port]        = (b == n - 1);
      #1;
      chk("req_valid", down_xfcp_out_tvalid, 1);
      chk("req_data", down_xfcp_out_tdata, base + 8'(b));
      chk("req_last", down_xfcp_out_tlast, (b == n - 1));
      chk("req_ready", up_xfcp_in_tready, 1 << port);
      cyc();
    end
    up_xfcp_in_tvalid[port] = 1'b0;
    up_xfcp_in_tlast[port]  = 1'b0;
  endtask

  // Sends one response frame from the switch; port < 0 means it must be dropped.
  task automatic rsp_frame(input int port, input int n, input logic [7:0] base);
    int w;
    for (int b = 0; b < n; b++) begin
      down_xfcp_in_tvalid = 1'b1;
      down_xfcp_in_tdata  = base + 8'(b);
      down_xfcp_in_tlast  = (b == n - 1);
      #1;
      w = 0;
      while (down_xfcp_in_tready !== 1'b1 && w < 10) begin
        chk("rsp_wait_valid", up_xfcp_out_tvalid, 0);
        cyc();
        w++;
      end
      chk("rsp_no_timeout", (w < 10), 1);
      if (port < 0) begin
        chk("drop_valid", up_xfcp_out_tvalid, 0);
      end else begin
        chk("rsp_valid", up_xfcp_out_tvalid, 1 << port);
        chk("rsp_data", up_xfcp_out_tdata[port*8 +: 8], base + 8'(b));
        chk("rsp_last", up_xfcp_out_tlast[port], (b == n - 1));
      end
      cyc();
    end
    down_xfcp_in_tvalid = 1'b0;
    down_xfcp_in_tlast  = 1'b0;
    if (port < 0) begin
      #1;
      chk("drop_pulse_hi", drop_pulse, 1);
      cyc();
      chk("drop_pulse_lo", drop_pulse, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst                  = 1'b1;
    up_xfcp_in_tdata     = '0;
    up_xfcp_in_tvalid    = '0;
    up_xfcp_in_tlast     = '0;
    up_xfcp_in_tuser     = '0;
    up_xfcp_out_tready   = '1;
    down_xfcp_out_tready = 1'b1;
    down_xfcp_in_tdata   = '0;
    down_xfcp_in_tvalid  = 1'b0;
    down_xfcp_in_tlast   = 1'b0;
    down_xfcp_in_tuser   = 1'b0;
    repeat (3) cyc();
    chk("rst_down_valid", down_xfcp_out_tvalid, 0);
    chk("rst_up_ready", up_xfcp_in_tready, 0);
    chk("rst_up_valid", up_xfcp_out_tvalid, 0);
    chk("rst_down_ready", down_xfcp_in_tready, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_drop", drop_pulse, 0);
    rst = 1'b0;
    cyc();

    // Simultaneous requests: port 0 first, port 1 after one idle cycle.
    up_xfcp_in_tvalid[1]   = 1'b1;
    up_xfcp_in_tdata[15:8] = 8'h21;
    req_frame(0, 2, 8'h11, 1);
    req_frame(1, 2, 8'h21, 1);
    chk("t2_outstanding", outstanding, 2);
    rsp_frame(0, 2, 8'hA0);
    rsp_frame(1, 2, 8'hB0);
    chk("t2_drained", outstanding, 0);

    // Single 4-byte request from port 0, 3-byte response.
    chk("t1_out0", outstanding, 0);
    req_frame(0, 4, 8'h01, 1);
    chk("t1_out1", outstanding, 1);
    rsp_frame(0, 3, 8'hC0);
    chk("t1_out_end", outstanding, 0);

    // Port 1 holds valid; port 0 joins: grants 1, 0, 1.
    up_xfcp_in_tvalid[1]   = 1'b1;
    up_xfcp_in_tdata[15:8] = 8'h31;
    up_xfcp_in_tlast[1]    = 1'b1;
    cyc();
    chk("t3_g1_data", down_xfcp_out_tdata, 8'h31);
    chk("t3_g1_ready", up_xfcp_in_tready, 2'b10);
    up_xfcp_in_tvalid[0]  = 1'b1;
    up_xfcp_in_tdata[7:0] = 8'h30;
    up_xfcp_in_tlast[0]   = 1'b1;
    cyc();
    chk("t3_idle1", down_xfcp_out_tvalid, 0);
    cyc();
    chk("t3_g2_data", down_xfcp_out_tdata, 8'h30);
    chk("t3_g2_ready", up_xfcp_in_tready, 2'b01);
    cyc();
    up_xfcp_in_tvalid[0] = 1'b0;
    up_xfcp_in_tlast[0]  = 1'b0;
    #1;
    chk("t3_idle2", down_xfcp_out_tvalid, 0);
    cyc();
    chk("t3_g3_data", down_xfcp_out_tdata, 8'h31);
    chk("t3_g3_ready", up_xfcp_in_tready, 2'b10);
    cyc();
    up_xfcp_in_tvalid[1] = 1'b0;
    up_xfcp_in_tlast[1]  = 1'b0;
    chk("t3_outstanding", outstanding, 3);
    rsp_frame(1, 1, 8'hD1);
    rsp_frame(0, 1, 8'hD0);
    rsp_frame(1, 1, 8'hD2);
    chk("t3_drained", outstanding, 0);

    // Both ports stream single-byte requests until the route FIFO fills.
    up_xfcp_in_tvalid = 2'b11;
    up_xfcp_in_tdata  = 16'h4140;
    up_xfcp_in_tlast  = 2'b11;
    for (int g = 0; g < 4; g++) begin
      cyc();
      chk("t4_grant_data", down_xfcp_out_tdata, 8'h40 + 8'(g % 2));
      chk("t4_grant_ready", up_xfcp_in_tready, 1 << (g % 2));
      cyc();
    end
    chk("t4_full_count", outstanding, 4);
    for (int i = 0; i < 3; i++) begin
      chk("t4_full_ready", up_xfcp_in_tready, 0);
      chk("t4_full_valid", down_xfcp_out_tvalid, 0);
      cyc();
    end
    rsp_frame(0, 1, 8'hE0);
    chk("t4_freed", outstanding, 3);
    cyc();
    chk("t4_fifth_data", down_xfcp_out_tdata, 8'h40);
    chk("t4_fifth_ready", up_xfcp_in_tready, 2'b01);
    chk("t4_refull", outstanding, 4);
    cyc();
    up_xfcp_in_tvalid = 2'b00;
    up_xfcp_in_tlast  = 2'b00;
    rsp_frame(1, 1, 8'hE1);
    rsp_frame(0, 1, 8'hE2);
    rsp_frame(1, 1, 8'hE3);
    rsp_frame(0, 1, 8'hE4);
    chk("t4_drained", outstanding, 0);

    // Unsolicited response is swallowed.
    rsp_frame(-1, 3, 8'hF0);
    chk("t5_outstanding", outstanding, 0);

    // Reset in the middle of a 5-byte request.
    up_xfcp_in_tvalid[0]  = 1'b1;
    up_xfcp_in_tdata[7:0] = 8'h61;
    cyc();
    chk("t6_beat1", down_xfcp_out_tdata, 8'h61);
    cyc();
    up_xfcp_in_tdata[7:0] = 8'h62;
    #1;
    chk("t6_beat2", down_xfcp_out_tdata, 8'h62);
    rst = 1'b1;
    cyc();
    chk("t6_rst_valid", down_xfcp_out_tvalid, 0);
    chk("t6_rst_ready", up_xfcp_in_tready, 0);
    chk("t6_rst_outstanding", outstanding, 0);
    rst = 1'b0;
    up_xfcp_in_tvalid[0] = 1'b0;
    cyc();
    req_frame(0, 2, 8'h71, 1);
    chk("t6_out1", outstanding, 1);
    rsp_frame(0, 1, 8'h81);
    chk("t6_out0", outstanding, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
